// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sequencer state encoding and the default widths.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

    // True when the address targets the hardwired-zero entry.
    function automatic logic rf_zero_hit(input logic [31:0] addr, input logic zero_reg);
        return zero_reg && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or on request,
// issuing one zeroing write per cycle while busy_o is high.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_o    = 1'b0;
        clr_we    = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                if (clear_i) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
            RF_CLEAR: begin
                busy_o    = 1'b1;
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two write
// ports with A-over-B priority, write-to-read bypass and a zeroing sequencer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wa_en_i,
    input  logic [ADDR_W-1:0]        wa_addr_i,
    input  logic [DATA_W-1:0]        wa_data_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i
);

    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wa_commit;
    logic              wb_commit;
    logic [DATA_W-1:0] mem [DEPTH];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .busy_o   (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy_o = busy;

    // Same qualification drives both the array write and the bypass path,
    // so a dropped write can never show up on a read port.
    assign wa_commit = wa_en_i && !busy && !rf_zero_hit(32'(wa_addr_i), ZERO_EN);
    assign wb_commit = wb_en_i && !busy && !rf_zero_hit(32'(wb_addr_i), ZERO_EN)
                       && !(wa_commit && (wa_addr_i == wb_addr_i));

    // NOTE: the array has no reset; the clear sequencer zeroes it after reset release.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wa_commit) mem[wa_addr_i] <= wa_data_i;
            if (wb_commit) mem[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            if (busy) begin
                data = '0;
            end else if (rf_zero_hit(32'(addr), ZERO_EN)) begin
                data = '0;
            end else if (wa_commit && (wa_addr_i == addr)) begin
                data = wa_data_i;
            end else if (wb_commit && (wb_addr_i == addr)) begin
                data = wb_data_i;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected read/busy values,
// a negedge monitor pops and compares them against two DUTs (ZERO_REG=1 and 0).
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam int SIG_RD0    = 0;
    localparam int SIG_RD1    = 1;
    localparam int SIG_BUSY   = 2;
    localparam int SIG_NZ_RD0 = 3;

    logic                     clk_i   = 1'b0;
    logic                     rst_ni  = 1'b0;
    logic                     clear_i = 1'b0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic                     wa_en   = 1'b0;
    logic [ADDR_W-1:0]        wa_addr = '0;
    logic [DATA_W-1:0]        wa_data = '0;
    logic                     wb_en   = 1'b0;
    logic [ADDR_W-1:0]        wb_addr = '0;
    logic [DATA_W-1:0]        wb_data = '0;

    logic                     busy;
    logic                     busy_nz;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD*DATA_W-1:0] rd_data_nz;

    regfile_mp #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .ZERO_REG (1)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .busy_o    (busy),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wa_en_i   (wa_en),
        .wa_addr_i (wa_addr),
        .wa_data_i (wa_data),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data)
    );

    regfile_mp #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .ZERO_REG (0)
    ) dut_nz (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .busy_o    (busy_nz),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data_nz),
        .wa_en_i   (wa_en),
        .wa_addr_i (wa_addr),
        .wa_data_i (wa_data),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: inputs settle 1 ns after posedge; everything queued is compared at negedge.
    always @(negedge clk_i) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sig)
                SIG_RD0:    act = rd_data[0 +: DATA_W];
                SIG_RD1:    act = rd_data[DATA_W +: DATA_W];
                SIG_BUSY:   act = {31'd0, busy};
                SIG_NZ_RD0: act = rd_data_nz[0 +: DATA_W];
                default:    act = 'x;
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic idle_inputs();
        clear_i = 1'b0;
        wa_en   = 1'b0;
        wb_en   = 1'b0;
    endtask

    task automatic write_a(input int addr, input logic [31:0] data);
        wa_en   = 1'b1;
        wa_addr = ADDR_W'(addr);
        wa_data = data;
    endtask

    task automatic write_b(input int addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = ADDR_W'(addr);
        wb_data = data;
    endtask

    initial begin
        // 1. Reset release: busy for DEPTH cycles, reads forced to zero, then all zero.
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) cyc();
            set_rd(0, i);
            set_rd(1, DEPTH - 1 - i);
            push($sformatf("rst_busy_c%0d", i), SIG_BUSY, 32'd1);
            push($sformatf("rst_rd0_c%0d", i), SIG_RD0, 32'd0);
        end
        cyc();
        push("rst_busy_done", SIG_BUSY, 32'd0);
        for (int i = 0; i < DEPTH / 2; i++) begin
            if (i > 0) cyc();
            set_rd(0, i);
            set_rd(1, i + DEPTH / 2);
            push($sformatf("zero_r%0d", i), SIG_RD0, 32'd0);
            push($sformatf("zero_r%0d", i + DEPTH / 2), SIG_RD1, 32'd0);
        end

        // 2. Port A write with same-cycle bypass, then stored value.
        cyc();
        write_a(5, 32'hDEAD_BEEF);
        set_rd(0, 5);
        push("bypass_a_r5", SIG_RD0, 32'hDEAD_BEEF);
        cyc();
        idle_inputs();
        push("stored_r5", SIG_RD0, 32'hDEAD_BEEF);

        // 3. A/B collision on r7 (A wins), then B-only write to r9.
        cyc();
        write_a(7, 32'h11);
        write_b(7, 32'h22);
        set_rd(1, 7);
        push("collide_bypass_r7", SIG_RD1, 32'h11);
        cyc();
        idle_inputs();
        push("collide_stored_r7", SIG_RD1, 32'h11);
        cyc();
        write_b(9, 32'h33);
        set_rd(0, 9);
        push("bypass_b_r9", SIG_RD0, 32'h33);
        cyc();
        idle_inputs();
        push("stored_r9", SIG_RD0, 32'h33);
        push("r7_after_b", SIG_RD1, 32'h11);

        // 4. Write to r0: hardwired zero vs. ordinary entry.
        cyc();
        write_a(0, 32'hFFFF_FFFF);
        set_rd(0, 0);
        push("zero_reg_same", SIG_RD0, 32'd0);
        push("nz_r0_bypass", SIG_NZ_RD0, 32'hFFFF_FFFF);
        cyc();
        idle_inputs();
        push("zero_reg_next", SIG_RD0, 32'd0);
        push("nz_r0_stored", SIG_NZ_RD0, 32'hFFFF_FFFF);

        // 5. Clear request with a same-cycle write, writes held during busy are dropped.
        cyc();
        write_a(3, 32'hA5);
        cyc();
        write_a(6, 32'h66);
        clear_i = 1'b1;
        set_rd(0, 3);
        set_rd(1, 6);
        push("pre_clear_r3", SIG_RD0, 32'hA5);
        push("clear_cycle_bypass_r6", SIG_RD1, 32'h66);
        push("clear_cycle_busy", SIG_BUSY, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            clear_i = (i == 10);
            write_a(4, 32'h5A);
            set_rd(0, 4);
            set_rd(1, 3);
            push($sformatf("clr_busy_c%0d", i), SIG_BUSY, 32'd1);
            push($sformatf("clr_no_bypass_c%0d", i), SIG_RD0, 32'd0);
            push($sformatf("clr_r3_c%0d", i), SIG_RD1, 32'd0);
        end
        cyc();
        idle_inputs();
        push("clr_busy_done", SIG_BUSY, 32'd0);
        push("clr_r4_dropped", SIG_RD0, 32'd0);
        push("clr_r3_zeroed", SIG_RD1, 32'd0);
        cyc();
        set_rd(0, 6);
        set_rd(1, 5);
        push("clr_r6_zeroed", SIG_RD0, 32'd0);
        push("clr_r5_zeroed", SIG_RD1, 32'd0);

        // 6. Reset pulse at clr_idx=10 restarts a full-length sequence.
        cyc();
        clear_i = 1'b1;
        push("rst_mid_req_busy", SIG_BUSY, 32'd0);
        for (int i = 0; i <= 10; i++) begin
            cyc();
            clear_i = 1'b0;
            if (i == 10) rst_ni = 1'b0;
            push($sformatf("pre_rst_busy_c%0d", i), SIG_BUSY, 32'd1);
        end
        cyc();
        rst_ni = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) cyc();
            push($sformatf("restart_busy_c%0d", i), SIG_BUSY, 32'd1);
        end
        cyc();
        push("restart_busy_done", SIG_BUSY, 32'd0);
        cyc();
        write_a(2, 32'h22);
        set_rd(0, 2);
        push("post_restart_bypass", SIG_RD0, 32'h22);
        cyc();
        idle_inputs();
        push("post_restart_stored", SIG_RD0, 32'h22);

        cyc();
        cyc();
        if (sb_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
